// File: rtl/cipher_sequencer_pkg.sv
// rtl/cipher_sequencer_pkg.sv - shared cipher sequencer types and defaults
package cipher_sequencer_pkg;

   // Default geometry of a block cipher job
   localparam int DEF_ROUNDS = 16;
   localparam int DEF_DW     = 32;
   localparam int DEF_KW     = 64;

   // Round index width; 5 bits covers ROUNDS up to 31 without wrapping
   localparam int IDX_W = 5;

   // Sequencer FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2,
      ST_OUT   = 2'd3
   } seq_state_t;

endpackage

// File: rtl/cipher_sequencer_if.sv
// rtl/cipher_sequencer_if.sv - block load, round function and ciphertext bus
interface cipher_sequencer_if
   import cipher_sequencer_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int KW = DEF_KW
) ();

   // Upstream collector
   logic             in_done;
   logic [DW-1:0]    in_data;
   logic [KW-1:0]    in_key;

   // External combinational round function
   logic [DW-1:0]    rf_state_in;
   logic [KW-1:0]    rf_key_in;
   logic [IDX_W-1:0] rf_idx;
   logic [DW-1:0]    rf_state_out;
   logic [KW-1:0]    rf_key_out;

   // Ciphertext output and status
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic             err_overrun;

   // Sequencer side
   modport slave (
      input  in_done, in_data, in_key, rf_state_out, rf_key_out, out_ready,
      output rf_state_in, rf_key_in, rf_idx, busy, out_valid, out_data, err_overrun
   );

   // Environment side: collector, round function and downstream consumer
   modport master (
      output in_done, in_data, in_key, rf_state_out, rf_key_out, out_ready,
      input  rf_state_in, rf_key_in, rf_idx, busy, out_valid, out_data, err_overrun
   );

endinterface

// File: rtl/cipher_sequencer.sv
// rtl/cipher_sequencer.sv - iterates an external round function over one block
module cipher_sequencer
   import cipher_sequencer_pkg::*;
#(
   parameter int ROUNDS = DEF_ROUNDS,
   parameter int DW     = DEF_DW,
   parameter int KW     = DEF_KW
) (
   input  logic               clk,
   input  logic               reset,
   cipher_sequencer_if.slave  bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);

   seq_state_t       state_q;
   seq_state_t       state_d;
   logic [DW-1:0]    state_reg;
   logic [KW-1:0]    key_reg;
   logic [IDX_W-1:0] cnt;
   logic             err_q;

   logic             do_load;
   logic             do_round;
   logic             do_final;
   logic             set_overrun;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state and datapath strobes; a load while leaving OUT chains straight into ROUND
   always_comb begin
      state_d     = state_q;
      do_load     = 1'b0;
      do_round    = 1'b0;
      do_final    = 1'b0;
      set_overrun = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_done) begin
               do_load = 1'b1;
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            do_round    = 1'b1;
            set_overrun = bus.in_done;
            if (cnt == LAST_IDX) state_d = ST_FINAL;
         end
         ST_FINAL: begin
            do_final    = 1'b1;
            set_overrun = bus.in_done;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               if (bus.in_done) begin
                  do_load = 1'b1;
                  state_d = ST_ROUND;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               set_overrun = bus.in_done;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Block state, round key and round counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= '0;
         key_reg   <= '0;
         cnt       <= '0;
      end else if (do_load) begin
         state_reg <= bus.in_data;
         key_reg   <= bus.in_key;
         cnt       <= IDX_W'(1);
      end else if (do_round) begin
         state_reg <= bus.rf_state_out;
         key_reg   <= bus.rf_key_out;
         if (cnt != LAST_IDX) cnt <= cnt + IDX_W'(1);
      end else if (do_final) begin
         state_reg <= state_reg ^ key_reg[KW-1 -: DW];
      end
   end

   // Sticky overrun flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset)            err_q <= 1'b0;
      else if (set_overrun) err_q <= 1'b1;
   end

   assign bus.rf_state_in = state_reg;
   assign bus.rf_key_in   = key_reg;
   assign bus.rf_idx      = (state_q == ST_ROUND) ? cnt : '0;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.out_valid   = (state_q == ST_OUT);
   assign bus.out_data    = state_reg;
   assign bus.err_overrun = err_q;

endmodule

// File: tb/tb_cipher_sequencer.sv
// tb/tb_cipher_sequencer.sv - directed self-checking bench for cipher_sequencer
module tb_cipher_sequencer;

   logic clk;
   logic reset;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   cipher_sequencer_if #(.DW(32), .KW(64)) bus ();

   cipher_sequencer #(.ROUNDS(4), .DW(32), .KW(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Round function stub: state + 1, key rotated left by 8
   assign bus.rf_state_out = bus.rf_state_in + 32'd1;
   assign bus.rf_key_out   = {bus.rf_key_in[55:0], bus.rf_key_in[63:56]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [31:0] data, input logic [63:0] key);
      bus.in_done = 1'b1;
      bus.in_data = data;
      bus.in_key  = key;
      tick();
      bus.in_done = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_done   = 1'b0;
      bus.in_data   = '0;
      bus.in_key    = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_busy",  64'(bus.busy), 64'd0);
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_data",  64'(bus.out_data), 64'd0);
      check("rst_err",   64'(bus.err_overrun), 64'd0);
      check("rst_idx",   64'(bus.rf_idx), 64'd0);
      check("rst_key",   bus.rf_key_in, 64'd0);

      // Basic block: data 0, key 1
      bus.out_ready = 1'b1;
      load(32'h0000_0000, 64'h0000_0000_0000_0001);
      check("basic_busy", 64'(bus.busy), 64'd1);
      check("basic_idx1", 64'(bus.rf_idx), 64'd1);
      check("basic_st1",  64'(bus.rf_state_in), 64'd0);
      tick();
      check("basic_idx2", 64'(bus.rf_idx), 64'd2);
      tick();
      check("basic_idx3", 64'(bus.rf_idx), 64'd3);
      tick();
      check("basic_idx4", 64'(bus.rf_idx), 64'd4);
      check("basic_v4",   64'(bus.out_valid), 64'd0);
      tick();
      check("basic_fin_idx", 64'(bus.rf_idx), 64'd0);
      check("basic_fin_v",   64'(bus.out_valid), 64'd0);
      check("basic_fin_st",  64'(bus.rf_state_in), 64'd4);
      check("basic_fin_key", bus.rf_key_in, 64'h0000_0001_0000_0000);
      tick();
      check("basic_valid", 64'(bus.out_valid), 64'd1);
      check("basic_data",  64'(bus.out_data), 64'h5);
      tick();
      check("basic_idle", 64'(bus.busy), 64'd0);
      check("basic_idle_v", 64'(bus.out_valid), 64'd0);

      // Backpressure: hold OUT for 10 cycles
      bus.out_ready = 1'b0;
      load(32'h0000_0000, 64'h0000_0000_0000_0001);
      for (int i = 0; i < 5; i++) tick();
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 64'(bus.out_valid), 64'd1);
         check("bp_data",  64'(bus.out_data), 64'h5);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      check("bp_idle", 64'(bus.busy), 64'd0);
      check("bp_idle_v", 64'(bus.out_valid), 64'd0);

      // Back-to-back: second block loaded on the accepting edge
      bus.out_ready = 1'b0;
      load(32'h0000_0000, 64'h0000_0000_0000_0001);
      for (int i = 0; i < 5; i++) tick();
      check("b2b_first", 64'(bus.out_data), 64'h5);
      bus.out_ready = 1'b1;
      load(32'h0000_0010, 64'h0000_0000_0000_0001);
      check("b2b_idx1",  64'(bus.rf_idx), 64'd1);
      check("b2b_v",     64'(bus.out_valid), 64'd0);
      check("b2b_st",    64'(bus.rf_state_in), 64'h10);
      for (int i = 0; i < 5; i++) tick();
      check("b2b_valid", 64'(bus.out_valid), 64'd1);
      check("b2b_data",  64'(bus.out_data), 64'h15);
      check("b2b_err",   64'(bus.err_overrun), 64'd0);
      tick();
      check("b2b_idle", 64'(bus.busy), 64'd0);

      // Overrun: in_done during round 2
      load(32'h0000_0000, 64'h0000_0000_0000_0001);
      tick();
      check("ovr_idx2", 64'(bus.rf_idx), 64'd2);
      load(32'h0000_00FF, 64'hFFFF_FFFF_FFFF_FFFF);
      check("ovr_idx3", 64'(bus.rf_idx), 64'd3);
      check("ovr_err",  64'(bus.err_overrun), 64'd1);
      tick();
      tick();
      tick();
      check("ovr_valid", 64'(bus.out_valid), 64'd1);
      check("ovr_data",  64'(bus.out_data), 64'h5);
      tick();
      tick();
      check("ovr_sticky", 64'(bus.err_overrun), 64'd1);
      check("ovr_idle",   64'(bus.busy), 64'd0);

      // Reset mid-operation during round 3
      load(32'h0000_0000, 64'h0000_0000_0000_0001);
      tick();
      tick();
      check("mrst_idx3", 64'(bus.rf_idx), 64'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_busy",  64'(bus.busy), 64'd0);
      check("mrst_valid", 64'(bus.out_valid), 64'd0);
      check("mrst_data",  64'(bus.out_data), 64'd0);
      check("mrst_err",   64'(bus.err_overrun), 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mrst_quiet", 64'(bus.out_valid), 64'd0);
      end
      load(32'h0000_0010, 64'h0000_0000_0000_0001);
      for (int i = 0; i < 5; i++) tick();
      check("mrst_after_v",    64'(bus.out_valid), 64'd1);
      check("mrst_after_data", 64'(bus.out_data), 64'h15);
      tick();
      check("mrst_after_idle", 64'(bus.busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cipher_sequencer.md
CIPHER_SEQUENCER -- requirements
Module: cipher_sequencer

Interface
REQ-001 Parameter ROUNDS, default 16, number of round iterations per block (legal range 1..31).
REQ-002 Parameter DW, default 32, block (data) width in bits.
REQ-003 Parameter KW, default 64, key width in bits (KW >= DW).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_done  input  1  single-cycle pulse from the upstream input collector: block and key are valid this cycle.
REQ-007 in_data  input  DW  collected plaintext block.
REQ-008 in_key  input  KW  collected key.
REQ-009 rf_state_in  output  DW  current state register, driven to the external combinational round function.
REQ-010 rf_key_in  output  KW  current key register, driven to the round function.
REQ-011 rf_idx  output  5  current round index, 1..ROUNDS while in ROUND, 0 otherwise.
REQ-012 rf_state_out  input  DW  round-function state result.
REQ-013 rf_key_out  input  KW  round-function next round key.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 out_valid  output  1  ciphertext valid, high only in OUT.
REQ-016 out_ready  input  1  downstream accepts ciphertext.
REQ-017 out_data  output  DW  ciphertext, equal to the state register.
REQ-018 err_overrun  output  1  sticky flag: a block was dropped.

Function
REQ-019 FSM states SHALL be IDLE, ROUND, FINAL, OUT.
REQ-020 IDLE: in_done=1 -> state_reg<=in_data, key_reg<=in_key, cnt<=1, next ROUND; otherwise hold.
REQ-021 ROUND: each cycle -> state_reg<=rf_state_out, key_reg<=rf_key_out; if cnt==ROUNDS next FINAL, else cnt<=cnt+1.
REQ-022 FINAL: one cycle -> state_reg<=state_reg XOR key_reg[KW-1:KW-DW]; next OUT.
REQ-023 OUT: out_valid=1, out_data stable until accepted; out_ready=1 -> next IDLE.
REQ-024 Latency: first out_valid cycle SHALL begin ROUNDS+1 cycles after the load edge; no combinational path from any input to out_valid.
REQ-025 Back-to-back: in OUT with out_ready=1 and in_done=1 in the same cycle, the new block SHALL be loaded as in REQ-020 and the FSM goes directly to ROUND; no overrun.
REQ-026 in_done=1 in ROUND, FINAL, or OUT (without out_ready) SHALL be ignored and SHALL set err_overrun; the block in flight is unaffected.
REQ-027 err_overrun SHALL clear only on reset.
REQ-028 cnt SHALL be 5 bits wide; rf_idx=cnt in ROUND, 0 in other states; it never wraps because ROUNDS<=31.
REQ-029 rf_state_in/rf_key_in SHALL always equal state_reg/key_reg.

Reset
REQ-030 reset=1 SHALL force IDLE, state_reg=0, key_reg=0, cnt=0, err_overrun=0, so busy=0, out_valid=0, out_data=0 on the next cycle.
REQ-031 Reset SHALL take priority over all inputs, including mid-ROUND and while in OUT; a block in flight is discarded with no output.

Structure
REQ-032 The shared cipher package SHALL hold the FSM state encoding, the DW/KW/ROUNDS defaults and the round-index width.
REQ-033 The round function SHALL stay outside this block; no sub-module is instantiated, and the FSM, counter and registers live in one module.

Verification (bench stub: rf_state_out=rf_state_in+1, rf_key_out=rf_key_in rotated left 8; ROUNDS=4)
REQ-034 Basic: in_data=0x00000000, in_key=0x0000000000000001, out_ready=1 -> out_valid rises 5 cycles after load with out_data=0x00000005; rf_idx sequence 1,2,3,4.
REQ-035 Backpressure: same block with out_ready=0 for 10 cycles -> out_valid and out_data=0x00000005 held stable; out_ready=1 -> IDLE next cycle.
REQ-036 Back-to-back: in_done coincident with out_ready in OUT, in_data=0x00000010 -> second block loaded that edge, second out_data=0x00000015, err_overrun=0.
REQ-037 Overrun: in_done pulse during ROUND round 2 -> err_overrun=1 and stays 1; first result still 0x00000005.
REQ-038 Reset mid-operation: reset during ROUND round 3 -> next cycle busy=0, out_valid=0, out_data=0, err_overrun=0; a following block completes normally.
